matrix_spi_rx: RTL

Receive-side counterpart of the LED matrix SPI output stage. Oversamples the multi-channel SPI bus (`spi_clk`, `spi_mosi[]`) and the 74HC595-style select chain (`shift_clk/ser/stcp/en`) on the system clock, then reassembles per-channel bytes, byte index and active select. Sits in loopback test builds and the matrix emulator: it consumes exactly what the transmitter drives and checks frame integrity.

---
 rtl/matrix_spi_pkg.sv | 14 +
 rtl/matrix_spi_rx_sync_edge.sv | 45 ++++
 rtl/matrix_spi_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/matrix_spi_pkg.sv
// Shared definitions for the LED matrix SPI transmitter and receiver.
// Receiver timeout is enabled by defining MATRIX_SPI_RX_TIMEOUT_EN.
package matrix_spi_pkg;

    localparam int SPI_SIZE                 = 8;
    localparam int DEFAULT_BYTES_PER_MATRIX = 8 * 16 * 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } rx_state_e;

endpackage

// File: rtl/matrix_spi_rx_sync_edge.sv
// Two-flop synchronizer; with EDGE set the output is a registered rising-edge
// pulse instead of the synchronized level.
module sync_edge #(
    parameter int WIDTH = 1,
    parameter bit EDGE  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
        end
    end

    if (EDGE) begin : g_edge
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] rise;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prev <= '0;
                rise <= '0;
            end else begin
                prev <= s2;
                rise <= s2 & ~prev;
            end
        end

        assign q = rise;
    end else begin : g_level
        assign q = s2;
    end

endmodule

// File: rtl/matrix_spi_rx.sv
// Oversampling receiver for the multi-lane matrix SPI bus and 595-style select chain.
// Define MATRIX_SPI_RX_TIMEOUT_EN to abort partial bytes after TIMEOUT_CYCLES idle clocks.
module matrix_spi_rx
    import matrix_spi_pkg::*;
#(
    parameter int CHANNEL_NUMBER   = 3,
    parameter int BYTES_PER_MATRIX = DEFAULT_BYTES_PER_MATRIX,
    parameter int SELECT_BITS      = 8,
    parameter int TIMEOUT_CYCLES   = 1000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               spi_clk,
    input  logic [CHANNEL_NUMBER-1:0]          spi_mosi,
    input  logic                               shift_clk,
    input  logic                               shift_ser,
    input  logic                               shift_stcp,
    input  logic                               shift_en,
    output logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rx_data,
    output logic                               rx_valid,
    output logic [$clog2(BYTES_PER_MATRIX)-1:0] rx_index,
    output logic [SELECT_BITS-1:0]             rx_select,
    output logic                               frame_done,
    output logic                               overrun,
    output logic                               timeout_err
);

    localparam int IDX_W = $clog2(BYTES_PER_MATRIX);
    localparam int BIT_W = $clog2(SPI_SIZE);
    localparam int DW    = CHANNEL_NUMBER * SPI_SIZE;

    logic                      spi_rise;
    logic                      shift_rise;
    logic                      stcp_rise;
    logic                      ser_s;
    logic                      en_s;
    logic [CHANNEL_NUMBER-1:0] mosi_s;

    sync_edge #(.WIDTH(1), .EDGE(1'b1)) u_sync_spi_clk (
        .clk(clk), .rst(rst), .async_in(spi_clk), .q(spi_rise)
    );
    sync_edge #(.WIDTH(1), .EDGE(1'b1)) u_sync_shift_clk (
        .clk(clk), .rst(rst), .async_in(shift_clk), .q(shift_rise)
    );
    sync_edge #(.WIDTH(1), .EDGE(1'b1)) u_sync_stcp (
        .clk(clk), .rst(rst), .async_in(shift_stcp), .q(stcp_rise)
    );
    sync_edge #(.WIDTH(1), .EDGE(1'b0)) u_sync_ser (
        .clk(clk), .rst(rst), .async_in(shift_ser), .q(ser_s)
    );
    sync_edge #(.WIDTH(1), .EDGE(1'b0)) u_sync_en (
        .clk(clk), .rst(rst), .async_in(shift_en), .q(en_s)
    );
    sync_edge #(.WIDTH(CHANNEL_NUMBER), .EDGE(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .async_in(spi_mosi), .q(mosi_s)
    );

    logic [SELECT_BITS-1:0] sreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg      <= '0;
            rx_select <= '0;
        end else begin
            if (shift_rise) begin
                sreg <= {sreg[SELECT_BITS-2:0], ser_s};
            end
            if (stcp_rise) begin
                rx_select <= sreg;
            end
        end
    end

    logic enabled;
    assign enabled = ~en_s & (|rx_select);

    logic [DW-1:0] shift;
    logic [DW-1:0] shift_next;

    always_comb begin
        shift_next = shift;
        for (int n = 0; n < CHANNEL_NUMBER; n++) begin
            shift_next[n*SPI_SIZE +: SPI_SIZE] = {shift[n*SPI_SIZE +: SPI_SIZE-1], mosi_s[n]};
        end
    end

    rx_state_e          state;
    logic [BIT_W-1:0]   bit_cnt;
    logic [IDX_W-1:0]   byte_cnt;

`ifdef MATRIX_SPI_RX_TIMEOUT_EN
    logic [$clog2(TIMEOUT_CYCLES+1)-1:0] idle_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // A select latch or dropped enable always wins over a coincident data edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_index   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
`ifdef MATRIX_SPI_RX_TIMEOUT_EN
            idle_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            if (stcp_rise || !enabled) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                shift    <= '0;
`ifdef MATRIX_SPI_RX_TIMEOUT_EN
                idle_cnt <= '0;
`endif
            end else begin
                case (state)
                    IDLE: state <= RECV;
                    RECV: begin
                        if (spi_rise) begin
                            shift <= shift_next;
`ifdef MATRIX_SPI_RX_TIMEOUT_EN
                            idle_cnt <= '0;
`endif
                            if (bit_cnt == BIT_W'(SPI_SIZE - 1)) begin
                                bit_cnt  <= '0;
                                rx_data  <= shift_next;
                                rx_valid <= 1'b1;
                                rx_index <= byte_cnt;
                                if (byte_cnt == IDX_W'(BYTES_PER_MATRIX - 1)) begin
                                    frame_done <= 1'b1;
                                    state      <= FULL;
                                end else begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
`ifdef MATRIX_SPI_RX_TIMEOUT_EN
                        else if (bit_cnt != '0) begin
                            if (idle_cnt == ($bits(idle_cnt))'(TIMEOUT_CYCLES - 1)) begin
                                bit_cnt     <= '0;
                                shift       <= '0;
                                idle_cnt    <= '0;
                                timeout_err <= 1'b1;
                            end else begin
                                idle_cnt <= idle_cnt + 1'b1;
                            end
                        end
`endif
                    end
                    FULL: begin
                        if (spi_rise) begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
